// File: rtl/fetch_queue.sv
// fetch_queue: owns the fetch PC, issues sequential imem word reads, buffers replies in an in-order DEPTH-entry queue.
// Latency: response to instr_valid is one cycle; zero cycles through the empty-queue bypass when FETCH_BYPASS_EN is defined.
// Backpressure: instr_ready low fills the queue; requests stall while queued + outstanding reaches DEPTH.
module fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_data,
    output logic [31:0] instr_pc,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);
    localparam int          AW  = $clog2(DEPTH);
    localparam int          CW  = AW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_head_pc;
    logic [31:0]   r_mem [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_out;
    logic [CW-1:0] r_drop;
    logic          r_run;

    logic          w_req_hs;
    logic          w_rsp_take;
    logic          w_qempty;
    logic          w_byp;
    logic          w_deliver;
    logic          w_qpop;
    logic          w_push;
    logic [CW:0]   w_inflight;
    logic [31:0]   w_redirect_pc;
    logic          w_unused;

    assign w_redirect_pc = {redirect_pc[31:2], 2'b00};
    assign w_unused      = ^redirect_pc[1:0];

    // Request stays up until accepted: inflight only shrinks while no request is taken.
    assign w_inflight     = (CW+1)'(r_count) + (CW+1)'(r_out);
    assign imem_req_valid = r_run && !redirect && (r_drop == '0) && (w_inflight < (CW+1)'(DEPTH));
    assign imem_req_addr  = r_fetch_pc;
    assign w_req_hs       = imem_req_valid && imem_req_ready;

    // A response is kept only when it is not stale and no redirect is squashing this cycle.
    assign w_rsp_take = imem_rsp_valid && (r_drop == '0) && !redirect;
    assign w_qempty   = (r_count == '0);

`ifdef FETCH_BYPASS_EN
    assign w_byp = w_qempty && w_rsp_take;
`else
    assign w_byp = 1'b0;
`endif

    assign instr_valid = !w_qempty || w_byp;
    assign instr_data  = !w_qempty ? r_mem[r_rd_ptr] : (w_byp ? imem_rsp_data : NOP);
    assign instr_pc    = r_head_pc;

    assign w_deliver = instr_valid && instr_ready && !redirect;
    assign w_qpop    = w_deliver && !w_qempty;
    // A bypassed word consumed by decode this cycle never occupies a slot.
    assign w_push    = w_rsp_take && !(w_byp && instr_ready);

    // PCs, counters and queue pointers; redirect flushes and reloads both PCs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run      <= 1'b0;
            r_fetch_pc <= RESET_PC;
            r_head_pc  <= RESET_PC;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_out      <= '0;
            r_drop     <= '0;
        end else begin
            r_run <= 1'b1;
            r_out <= r_out + CW'(w_req_hs) - CW'(imem_rsp_valid);
            if (redirect) begin
                r_fetch_pc <= w_redirect_pc;
                r_head_pc  <= w_redirect_pc;
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
                r_count    <= '0;
                r_drop     <= r_out - CW'(imem_rsp_valid);
            end else begin
                if (w_req_hs)
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                if (w_deliver)
                    r_head_pc <= r_head_pc + 32'd4;
                if (w_push)
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_qpop)
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                r_count <= r_count + CW'(w_push) - CW'(w_qpop);
                if (imem_rsp_valid && (r_drop != '0))
                    r_drop <= r_drop - 1'b1;
            end
        end
    end

    // Queue storage; contents are meaningless outside [rd_ptr, rd_ptr+count) so no reset.
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= imem_rsp_data;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_push && !w_qpop && (r_count == CW'(DEPTH))));
    a_no_spurious_rsp: assert property (@(posedge clk) disable iff (!rst_n)
        !(imem_rsp_valid && (r_out == '0)));
endmodule
